// File: rtl/bram_dp_true_be.sv
// +-----------------------------------------------------------------------+
// | bram_dp_true_be : true dual-port RAM with byte enables, collision      |
// | arbitration and optional output register.                 Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module bram_dp_true_be #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3,
  parameter int WRITE_MODE    = 0,
  parameter int OUT_REG       = 0,
  parameter int COLL_PRIO     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_a_i,
  input  logic                     en_b_i,
  input  logic [RAM_WIDTH/8-1:0]   we_a_i,
  input  logic [RAM_WIDTH/8-1:0]   we_b_i,
  input  logic [RAM_ADDR_BITS-1:0] addr_a_i,
  input  logic [RAM_ADDR_BITS-1:0] addr_b_i,
  input  logic [RAM_WIDTH-1:0]     data_a_i,
  input  logic [RAM_WIDTH-1:0]     data_b_i,
  output logic [RAM_WIDTH-1:0]     data_a_o,
  output logic [RAM_WIDTH-1:0]     data_b_o,
  output logic                     valid_a_o,
  output logic                     valid_b_o,
  output logic                     coll_o,
  output logic [7:0]               coll_cnt_o
);

  localparam int NB        = RAM_WIDTH / 8;
  localparam int RAM_DEPTH = 2 ** RAM_ADDR_BITS;

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                     en    [2];
  logic [NB-1:0]            we    [2];
  logic [RAM_ADDR_BITS-1:0] addr  [2];
  logic [RAM_WIDTH-1:0]     wdata [2];
  logic [RAM_WIDTH-1:0]     rdata [2];
  logic                     rvalid[2];

  assign en[0]    = en_a_i;
  assign en[1]    = en_b_i;
  assign we[0]    = we_a_i;
  assign we[1]    = we_b_i;
  assign addr[0]  = addr_a_i;
  assign addr[1]  = addr_b_i;
  assign wdata[0] = data_a_i;
  assign wdata[1] = data_b_i;

  logic [NB-1:0] coll_bytes;
  logic          coll;

  assign coll_bytes = (en_a_i && en_b_i && (addr_a_i == addr_b_i)) ? (we_a_i & we_b_i) : '0;
  assign coll       = |coll_bytes;

  function automatic logic [RAM_WIDTH-1:0] merge(input logic [RAM_WIDTH-1:0] old_w,
                                                 input logic [RAM_WIDTH-1:0] new_w,
                                                 input logic [NB-1:0]        be);
    logic [RAM_WIDTH-1:0] res;
    res = old_w;
    for (int k = 0; k < NB; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Overlapping bytes are suppressed on the losing port; the array is never reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < NB; k++) begin
        if (en_a_i && we_a_i[k] && !(coll_bytes[k] && COLL_PRIO == 1))
          mem[addr_a_i][8*k +: 8] <= data_a_i[8*k +: 8];
        if (en_b_i && we_b_i[k] && !(coll_bytes[k] && COLL_PRIO == 0))
          mem[addr_b_i][8*k +: 8] <= data_b_i[8*k +: 8];
      end
    end
  end

  generate
    for (genvar p = 0; p < 2; p++) begin : g_port
      logic [RAM_WIDTH-1:0] old_word;
      logic [RAM_WIDTH-1:0] s1_data;
      logic                 s1_valid;

      assign old_word = mem[addr[p]];

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          s1_data  <= '0;
          s1_valid <= 1'b0;
        end else begin
          s1_valid <= 1'b0;
          if (en[p]) begin
            if (!(|we[p])) begin
              s1_data  <= old_word;
              s1_valid <= 1'b1;
            end else if (WRITE_MODE == 1) begin
              s1_data  <= merge(old_word, wdata[p], we[p]);
              s1_valid <= 1'b1;
            end else if (WRITE_MODE != 2) begin
              s1_data  <= old_word;
              s1_valid <= 1'b1;
            end
          end
        end
      end

      if (OUT_REG == 1) begin : g_out_reg
        logic [RAM_WIDTH-1:0] out_data;
        logic                 out_valid;

        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            out_data  <= '0;
            out_valid <= 1'b0;
          end else begin
            out_valid <= s1_valid;
            if (s1_valid) out_data <= s1_data;
          end
        end

        assign rdata[p]  = out_data;
        assign rvalid[p] = out_valid;
      end else begin : g_no_out_reg
        assign rdata[p]  = s1_data;
        assign rvalid[p] = s1_valid;
      end
    end
  endgenerate

  assign data_a_o  = rdata[0];
  assign data_b_o  = rdata[1];
  assign valid_a_o = rvalid[0];
  assign valid_b_o = rvalid[1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      coll_o     <= 1'b0;
      coll_cnt_o <= 8'd0;
    end else begin
      coll_o <= coll;
      if (coll && coll_cnt_o != 8'hFF) coll_cnt_o <= coll_cnt_o + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_dp_true_be.sv
// +-----------------------------------------------------------------------+
// | tb_bram_dp_true_be : directed bench driving four parameter variants    |
// | with shared stimulus.                                      Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_bram_dp_true_be;

  // 0: READ_FIRST  1: WRITE_FIRST, COLL_PRIO=1  2: NO_CHANGE  3: OUT_REG=1
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, en_b;
  logic [1:0]  we_a, we_b;
  logic [2:0]  addr_a, addr_b;
  logic [15:0] din_a, din_b;

  logic [15:0] da [4];
  logic [15:0] db [4];
  logic        va [4];
  logic        vb [4];
  logic        co [4];
  logic [7:0]  cc [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_dp_true_be #(.WRITE_MODE(0), .OUT_REG(0), .COLL_PRIO(0)) u_rf (
    .clk_i(clk), .rst_ni(rst_n), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
    .data_a_o(da[0]), .data_b_o(db[0]), .valid_a_o(va[0]), .valid_b_o(vb[0]),
    .coll_o(co[0]), .coll_cnt_o(cc[0]));

  bram_dp_true_be #(.WRITE_MODE(1), .OUT_REG(0), .COLL_PRIO(1)) u_wf (
    .clk_i(clk), .rst_ni(rst_n), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
    .data_a_o(da[1]), .data_b_o(db[1]), .valid_a_o(va[1]), .valid_b_o(vb[1]),
    .coll_o(co[1]), .coll_cnt_o(cc[1]));

  bram_dp_true_be #(.WRITE_MODE(2), .OUT_REG(0), .COLL_PRIO(0)) u_nc (
    .clk_i(clk), .rst_ni(rst_n), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
    .data_a_o(da[2]), .data_b_o(db[2]), .valid_a_o(va[2]), .valid_b_o(vb[2]),
    .coll_o(co[2]), .coll_cnt_o(cc[2]));

  bram_dp_true_be #(.WRITE_MODE(0), .OUT_REG(1), .COLL_PRIO(0)) u_or (
    .clk_i(clk), .rst_ni(rst_n), .en_a_i(en_a), .en_b_i(en_b), .we_a_i(we_a), .we_b_i(we_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .data_a_i(din_a), .data_b_i(din_b),
    .data_a_o(da[3]), .data_b_o(db[3]), .valid_a_o(va[3]), .valid_b_o(vb[3]),
    .coll_o(co[3]), .coll_cnt_o(cc[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = 2'b00; we_b = 2'b00;
  endtask

  task automatic port_a(input logic [1:0] we, input logic [2:0] a, input logic [15:0] d);
    en_a = 1'b1; we_a = we; addr_a = a; din_a = d;
  endtask

  task automatic port_b(input logic [1:0] we, input logic [2:0] a, input logic [15:0] d);
    en_b = 1'b1; we_b = we; addr_b = a; din_b = d;
  endtask

  function automatic logic [15:0] val(input int i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  initial begin
    rst_n = 1'b0; idle();
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    tick(); tick();
    check("rst_data_a", 32'(da[0]), 32'h0);
    check("rst_valid_a", 32'(va[0]), 32'h0);
    check("rst_coll", 32'(co[0]), 32'h0);
    check("rst_cnt", 32'(cc[0]), 32'h0);
    check("rst_or_data", 32'(da[3]), 32'h0);
    rst_n = 1'b1;

    // fill and read-back
    port_a(2'b11, 3'd2, 16'h1111); tick();
    check("nc_write_novalid", 32'(va[2]), 32'h0);
    idle(); port_b(2'b00, 3'd2, 16'h0); tick();
    check("fill_rd_data", 32'(db[0]), 32'h1111);
    check("fill_rd_valid", 32'(vb[0]), 32'h1);
    idle(); tick();
    check("valid_pulse_end", 32'(vb[0]), 32'h0);
    check("data_hold", 32'(db[0]), 32'h1111);

    // byte enable
    port_a(2'b11, 3'd3, 16'hAAAA); tick();
    port_a(2'b01, 3'd3, 16'h5555); tick();
    idle(); port_b(2'b00, 3'd3, 16'h0); tick();
    check("byte_en", 32'(db[0]), 32'hAA55);
    idle();

    // same-port read-during-write modes
    port_a(2'b11, 3'd1, 16'h1234); tick();
    port_a(2'b00, 3'd1, 16'h0); tick();
    check("nc_pre_read", 32'(da[2]), 32'h1234);
    port_a(2'b11, 3'd1, 16'hBEEF); tick();
    check("rf_data", 32'(da[0]), 32'h1234);
    check("rf_valid", 32'(va[0]), 32'h1);
    check("wf_data", 32'(da[1]), 32'hBEEF);
    check("wf_valid", 32'(va[1]), 32'h1);
    check("nc_hold", 32'(da[2]), 32'h1234);
    check("nc_valid", 32'(va[2]), 32'h0);

    // cross-port write vs read on the same address returns the old word
    port_a(2'b11, 3'd1, 16'hCAFE); port_b(2'b00, 3'd1, 16'h0); tick();
    check("cross_old", 32'(db[0]), 32'hBEEF);
    idle(); port_b(2'b00, 3'd1, 16'h0); tick();
    check("cross_new", 32'(db[0]), 32'hCAFE);
    idle();

    // write-write collision
    port_a(2'b11, 3'd4, 16'h1122); port_b(2'b01, 3'd4, 16'h3344); tick();
    check("coll_pulse", 32'(co[0]), 32'h1);
    check("coll_cnt1", 32'(cc[0]), 32'h1);
    idle(); tick();
    check("coll_pulse_end", 32'(co[0]), 32'h0);
    port_b(2'b00, 3'd4, 16'h0); tick();
    check("coll_prio_a", 32'(db[0]), 32'h1122);
    check("coll_prio_b", 32'(db[1]), 32'h1144);
    idle();
    port_a(2'b11, 3'd4, 16'h1122); port_b(2'b01, 3'd4, 16'h3344);
    for (int i = 0; i < 299; i++) tick();
    check("coll_cnt_sat", 32'(cc[0]), 32'hFF);
    tick();
    check("coll_cnt_nowrap", 32'(cc[0]), 32'hFF);
    idle(); tick();

    // streaming with the output register
    for (int i = 0; i < 8; i++) begin
      port_a(2'b11, 3'(i), val(i)); tick();
    end
    idle(); tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) port_a(2'b00, 3'(i), 16'h0);
      else idle();
      tick();
      check($sformatf("or_valid_%0d", i), 32'(va[3]), 32'((i >= 1) && (i <= 8)));
      if (i >= 1 && i <= 8) check($sformatf("or_data_%0d", i), 32'(da[3]), 32'(val(i - 1)));
      check($sformatf("l1_valid_%0d", i), 32'(va[0]), 32'(i < 8));
      if (i < 8) check($sformatf("l1_data_%0d", i), 32'(da[0]), 32'(val(i)));
    end

    // reset mid-read; writes during reset must not land
    port_a(2'b00, 3'd5, 16'h0); tick();
    rst_n = 1'b0; port_a(2'b11, 3'd5, 16'hFFFF); tick();
    check("mid_rst_valid", 32'(va[3]), 32'h0);
    check("mid_rst_data", 32'(da[3]), 32'h0);
    check("mid_rst_data_l1", 32'(da[0]), 32'h0);
    check("mid_rst_cnt", 32'(cc[0]), 32'h0);
    tick();
    check("mid_rst_valid2", 32'(va[3]), 32'h0);
    rst_n = 1'b1; idle(); tick();
    check("post_rst_valid", 32'(va[3]), 32'h0);
    port_a(2'b00, 3'd5, 16'h0); tick();
    idle(); tick();
    check("reread_valid", 32'(va[3]), 32'h1);
    check("reread_data", 32'(da[3]), 32'(val(5)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_dp_true_be.md
BRAM_DP_TRUE_BE -- requirements
Module: bram_dp_true_be

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 16, data width in bits per port; legal values are multiples of 8 and at least 8.
REQ-002 SHALL have parameter RAM_ADDR_BITS, default 3, address width; depth RAM_DEPTH = 2**RAM_ADDR_BITS.
REQ-003 SHALL have parameter WRITE_MODE, default 0, same-port read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds an output pipeline register.
REQ-005 SHALL have parameter COLL_PRIO, default 0, write-write collision winner: 0 port A, 1 port B.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have ports en_a_i / en_b_i, input, 1 bit: port enable.
REQ-009 SHALL have ports we_a_i / we_b_i, input, RAM_WIDTH/8 bits: byte write enables; bit k covers data[8k+7:8k].
REQ-010 SHALL have ports addr_a_i / addr_b_i, input, RAM_ADDR_BITS bits: word address.
REQ-011 SHALL have ports data_a_i / data_b_i, input, RAM_WIDTH bits: write data.
REQ-012 SHALL have ports data_a_o / data_b_o, output, RAM_WIDTH bits: read data.
REQ-013 SHALL have ports valid_a_o / valid_b_o, output, 1 bit: data_x_o updated this cycle.
REQ-014 SHALL have port coll_o, output, 1 bit: one-cycle pulse on a write-write collision.
REQ-015 SHALL have port coll_cnt_o, output, 8 bits: saturating collision counter.

Function
REQ-016 SHALL write, for a port with en=1, each byte k with we[k]=1 to mem[addr] at the clock edge; bytes with we[k]=0 SHALL be unchanged.
REQ-017 SHALL perform a port access only when en=1; with en=0, the port SHALL neither write nor update data_x_o, and valid_x_o=0.
REQ-018 SHALL have read latency L = 1 + OUT_REG cycles from the enabled edge to data_x_o/valid_x_o; valid_x_o SHALL be a single-cycle pulse per access.
REQ-019 SHALL produce the same-port output during a write (|we=1) per mode: READ_FIRST returns old word; WRITE_FIRST returns merged new word; NO_CHANGE holds data_x_o and gives no valid pulse.
REQ-020 SHALL, when one port writes and the other reads the same address in the same cycle, return the old word to the reading port.
REQ-021 SHALL define a write-write collision as: both en=1, equal addresses, and (we_a_i & we_b_i) != 0.
REQ-022 SHALL, on collision, write overlapping bytes from the COLL_PRIO winner and non-overlapping bytes from their own port.
REQ-023 SHALL pulse coll_o one cycle after each collision edge.
REQ-024 SHALL increment coll_cnt_o by 1 per collision, saturating at 255 with no wrap.
REQ-025 SHALL keep data_x_o holding its last value between accesses.
REQ-026 SHALL hold the OUT_REG=1 pipeline stage data and valid separately per port, so back-to-back accesses on consecutive cycles stream at one result per cycle.
REQ-027 SHALL allow mem contents to power up undefined; no reset of the array.

Reset
REQ-028 SHALL, while rst_ni=0 at an edge, clear data_a_o, data_b_o, valid_a_o, valid_b_o, coll_o, coll_cnt_o and all pipeline stages to 0.
REQ-029 SHALL, while rst_ni=0 at an edge, perform no memory write, so array contents are preserved across reset.
REQ-030 SHALL discard any access in flight in the pipeline when reset is asserted mid-operation; no valid pulse appears after reset from pre-reset accesses.

Verification
REQ-031 SHALL cover fill and read-back (W=16, OUT_REG=0): A writes 0x1111 to addr 2 with we=11 -> next cycle B reads addr 2 -> data_b_o=0x1111 and valid_b_o=1 one cycle later.
REQ-032 SHALL cover byte enable: mem[3]=0xAAAA, A writes 0x5555 with we=01 -> read gives 0xAA55.
REQ-033 SHALL cover the three modes: mem[1]=0x1234, A writes 0xBEEF to addr 1 -> data_a_o is 0x1234 (READ_FIRST), 0xBEEF (WRITE_FIRST), or unchanged with valid_a_o=0 (NO_CHANGE).
REQ-034 SHALL cover collision (COLL_PRIO=0): A writes 0x1122 with we=11 and B writes 0x3344 with we=01, both to addr 4 -> mem[4]=0x1122, coll_o=1 for one cycle, coll_cnt_o=1; after 300 collisions coll_cnt_o=255.
REQ-035 SHALL cover OUT_REG=1 streaming: A reads addrs 0..7 on consecutive cycles -> valid_a_o is high 8 consecutive cycles starting 2 cycles later, data in address order.
REQ-036 SHALL cover reset mid-read (OUT_REG=1): rst_ni=0 on the cycle after a read is issued -> no valid_a_o pulse and outputs=0; after release, re-reading returns the pre-reset contents.
